load_queue_mw: RTL and testbench
================================

// Module: load_queue_mw
// PURPOSE
// - Parametrised in-order load queue between the load-address FUs and the D-cache read port.
// - Accepts up to WAYS address-computed loads per cycle; issues them to the cache in order, one per handshake.
// - Captures in-order cache responses and retires completed loads in order toward CDB/ROB.
// - Successor of the 2-way fixed-depth load buffer; adds cache backpressure, an outstanding-request limit and full/empty flow control.
// PARAMETERS
// - DEPTH    8   entries; power of two, >= WAYS
// - WAYS     2   allocation lanes per cycle
// - ADDR_W   32  load address width
// - DATA_W   32  load data width
// - TAG_W    8   opaque tag {pdest,rob,SQ,LQ idx}, carried unchanged
// - MAX_OUT  4   max cache requests in flight; 1..DEPTH
// PORTS
// - clock        in   1             rising-edge clock
// - reset        in   1             synchronous, active-high
// - wr_en        in   WAYS          per-lane allocate strobe
// - wr_addr      in   WAYS*ADDR_W   per-lane load address
// - wr_size      in   WAYS*3        per-lane mem_size
// - wr_tag       in   WAYS*TAG_W    per-lane tag
// - wr_ready     out  1             free entries >= WAYS
// - req_valid    out  1             cache read request pending
// - req_ready    in   1             cache accepts request this cycle
// - req_addr     out  ADDR_W        request address
// - req_size     out  3             request mem_size
// - resp_valid   in   1             cache returns data, oldest outstanding first
// - resp_data    in   DATA_W        returned data
// - out_valid    out  1             head load complete
// - out_ready    in   1             consumer pops head
// - out_data     out  DATA_W        head data
// - out_tag      out  TAG_W         head tag
// - out_size     out  3             head mem_size
// - count        out  $clog2(DEPTH)+1  occupied entries
// - empty        out  1             count == 0
// BEHAVIOUR
// - Three pointers, $clog2(DEPTH) bits, wrapping mod DEPTH: head (retire), iss (next to issue), tail (alloc); plus count and outstanding (0..MAX_OUT).
// - Reset: all pointers, count, outstanding, done bits = 0; wr_ready=1, empty=1, req_valid=0, out_valid=0, data outputs 0.
// - Allocation: set wr_en lanes written compacted in lane order, lowest lane at tail; tail += popcount(wr_en). Writes only legal when wr_ready; a write with wr_ready=0 is dropped entirely (no pointer/count change).
// - Issue: req_valid = (iss != tail || count == DEPTH) && iss entry not yet issued && outstanding < MAX_OUT; req_addr/size from entry[iss], 0 when !req_valid.
// - req_valid && req_ready: iss+1, outstanding+1. Request fields stable while req_valid && !req_ready.
// - Response: resp_valid writes resp_data into the oldest issued-not-done entry (resp pointer), sets done, outstanding-1. resp_valid with outstanding==0 is ignored.
// - Same-cycle issue + response: outstanding unchanged.
// - Retire: out_valid = !empty && done[head]; fields combinational from entry[head], 0 when !out_valid. out_valid && out_ready: clear done[head], head+1.
// - Latency: alloc->req_valid next cycle; resp->out_valid next cycle (no bypass).
// - count_next = count + popcount(accepted wr_en) - pop; same-cycle alloc and pop at full/near-full is legal because wr_ready uses current count.
// - Full (count==DEPTH): wr_ready=0, head==tail distinguished by count. Empty: out_valid=0, req_valid=0.
// - Reset mid-operation: all state cleared next edge; responses for requests in flight before reset are the cache's responsibility to cancel.
// CONFIGURATION
// - LOAD_QUEUE_FLUSH_EN defined: extra port flush (in, 1). On flush, next edge: head=iss=tail=0, count=0, done cleared, wr_en and out pop that cycle ignored; outstanding moves to drop counter; following resp_valid pulses decrement drop counter and are discarded until it reaches 0; req_valid held 0 while drop counter != 0.
// - Not defined: no flush port; queue only cleared by reset.
// TESTING
// - Reset, then idle -> empty=1, wr_ready=1, count=0, req_valid=0, out_valid=0.
// - wr_en=2'b11 addr 0x100/0x104, req_ready=1, resp 0xAA,0xBB one cycle later each, out_ready=1 -> out_data 0xAA then 0xBB, tags in order, empty after.
// - wr_en=2'b10 only, addr 0x200 -> entry written at tail (lane compaction), req_addr=0x200, count=1.
// - Fill to DEPTH=8 with req_ready=0 -> wr_ready=0 at count>=7, extra write dropped, count stays 8, req_addr stable.
// - req_ready=1, no responses -> exactly MAX_OUT=4 requests issued, req_valid=0 until a resp_valid.
// - FLUSH_EN: 3 outstanding, flush, then 3 resp_valid -> all dropped, out_valid=0; new load after drains completes normally.

Source files
------------

// File: rtl/load_queue_mw.sv
// In-order load queue: WAYS-wide allocate, one cache request per handshake, in-order retire.
// Optional flush port and in-flight response drop counter when LOAD_QUEUE_FLUSH_EN is defined.
module load_queue_mw #(
  parameter int DEPTH   = 8,
  parameter int WAYS    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 8,
  parameter int MAX_OUT = 4
) (
  input  logic                       clock,
  input  logic                       reset,
`ifdef LOAD_QUEUE_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic [WAYS-1:0]            wr_en,
  input  logic [WAYS*ADDR_W-1:0]     wr_addr,
  input  logic [WAYS*3-1:0]          wr_size,
  input  logic [WAYS*TAG_W-1:0]      wr_tag,
  output logic                       wr_ready,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [ADDR_W-1:0]          req_addr,
  output logic [2:0]                 req_size,
  input  logic                       resp_valid,
  input  logic [DATA_W-1:0]          resp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic [2:0]                 out_size,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [2:0]        size_q [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  issued_q, done_q;
  logic [PTR_W-1:0]  head_q, iss_q, tail_q, rsp_q;
  logic [CNT_W-1:0]  count_q;
  logic [OUT_W-1:0]  outst_q;

  logic flush_c;
  logic drop_busy;
`ifdef LOAD_QUEUE_FLUSH_EN
  logic [OUT_W-1:0] drop_q;
  assign flush_c   = flush;
  assign drop_busy = (drop_q != '0);
`else
  assign flush_c   = 1'b0;
  assign drop_busy = 1'b0;
`endif

  logic             full, accept, issue_fire, resp_fire, pop;
  logic [CNT_W-1:0] n_wr;
  logic [PTR_W-1:0] lane_slot [WAYS];

  // Compact the set lanes in lane order starting at tail.
  always_comb begin
    n_wr = '0;
    for (int i = 0; i < WAYS; i++) begin
      lane_slot[i] = tail_q + n_wr[PTR_W-1:0];
      if (wr_en[i]) n_wr = n_wr + CNT_W'(1);
    end
  end

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign wr_ready   = (CNT_W'(DEPTH) - count_q) >= CNT_W'(WAYS);
  assign accept     = wr_ready && !flush_c;
  assign req_valid  = ((iss_q != tail_q) || full) && !issued_q[iss_q]
                      && (outst_q < OUT_W'(MAX_OUT)) && !drop_busy;
  assign issue_fire = req_valid && req_ready;
  assign resp_fire  = resp_valid && (outst_q != '0) && !drop_busy;
  assign out_valid  = !empty && done_q[head_q];
  assign pop        = out_valid && out_ready && !flush_c;

  assign req_addr = req_valid ? addr_q[iss_q] : '0;
  assign req_size = req_valid ? size_q[iss_q] : '0;
  assign out_data = out_valid ? data_q[head_q] : '0;
  assign out_tag  = out_valid ? tag_q[head_q]  : '0;
  assign out_size = out_valid ? size_q[head_q] : '0;

  always_ff @(posedge clock) begin
    for (int i = 0; i < WAYS; i++) begin
      if (accept && wr_en[i]) begin
        addr_q[lane_slot[i]] <= wr_addr[i*ADDR_W +: ADDR_W];
        size_q[lane_slot[i]] <= wr_size[i*3 +: 3];
        tag_q[lane_slot[i]]  <= wr_tag[i*TAG_W +: TAG_W];
      end
    end
    if (resp_fire) data_q[rsp_q] <= resp_data;
  end

  always_ff @(posedge clock) begin
    if (reset || flush_c) begin
      head_q   <= '0;
      iss_q    <= '0;
      tail_q   <= '0;
      rsp_q    <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      issued_q <= '0;
      done_q   <= '0;
    end else begin
      if (accept) tail_q <= tail_q + n_wr[PTR_W-1:0];
      if (issue_fire) begin
        issued_q[iss_q] <= 1'b1;
        iss_q           <= iss_q + PTR_W'(1);
      end
      if (resp_fire) begin
        done_q[rsp_q] <= 1'b1;
        rsp_q         <= rsp_q + PTR_W'(1);
      end
      // A popped head is always done, so it never aliases iss or rsp here.
      if (pop) begin
        done_q[head_q]   <= 1'b0;
        issued_q[head_q] <= 1'b0;
        head_q           <= head_q + PTR_W'(1);
      end
      count_q <= count_q + (accept ? n_wr : '0) - CNT_W'(pop);
      outst_q <= outst_q + OUT_W'(issue_fire) - OUT_W'(resp_fire);
    end
  end

`ifdef LOAD_QUEUE_FLUSH_EN
  // Requests still in the cache at flush time must have their responses swallowed.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_q <= '0;
    end else if (flush_c) begin
      drop_q <= drop_q + outst_q + OUT_W'(issue_fire)
                - OUT_W'(resp_valid && (drop_busy || outst_q != '0));
    end else if (drop_busy && resp_valid) begin
      drop_q <= drop_q - OUT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_load_queue_mw.sv
// Bench for load_queue_mw: queue-level reference model checked every cycle plus literal spot checks.
module tb_load_queue_mw;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  wr_en = '0;
  logic [63:0] wr_addr = '0;
  logic [5:0]  wr_size = '0;
  logic [15:0] wr_tag = '0;
  logic        wr_ready, req_valid, req_ready = 1'b0;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_data;
  logic [7:0]  out_tag;
  logic [2:0]  out_size;
  logic [3:0]  count;
  logic        empty;
`ifdef LOAD_QUEUE_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  load_queue_mw dut (
    .clock(clock), .reset(reset),
`ifdef LOAD_QUEUE_FLUSH_EN
    .flush(flush),
`endif
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_size(wr_size), .wr_tag(wr_tag),
    .wr_ready(wr_ready), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .resp_valid(resp_valid),
    .resp_data(resp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_size(out_size),
    .count(count), .empty(empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: loads in program order; issued and completed loads form prefixes.
  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  tag;
    logic [31:0] data;
  } ent_t;
  ent_t mq[$];
  int   n_iss = 0, n_done = 0, drop = 0;
  bit   chk_en = 0;

  always @(negedge clock) begin : model
    int   outs;
    bit   e_wr, e_rv, e_ov, fl;
    ent_t e;
    outs = n_iss - n_done;
    e_wr = (8 - mq.size()) >= 2;
    e_rv = (n_iss < mq.size()) && (outs < 4) && (drop == 0);
    e_ov = (n_done > 0);
`ifdef LOAD_QUEUE_FLUSH_EN
    fl = flush;
`else
    fl = 1'b0;
`endif
    if (chk_en) begin
      chk("m_count", count, mq.size());
      chk("m_empty", empty, mq.size() == 0);
      chk("m_wr_ready", wr_ready, e_wr);
      chk("m_req_valid", req_valid, e_rv);
      chk("m_req_addr", req_addr, e_rv ? mq[n_iss].addr : 32'h0);
      chk("m_req_size", req_size, e_rv ? mq[n_iss].size : 3'h0);
      chk("m_out_valid", out_valid, e_ov);
      chk("m_out_data", out_data, e_ov ? mq[0].data : 32'h0);
      chk("m_out_tag", out_tag, e_ov ? mq[0].tag : 8'h0);
      chk("m_out_size", out_size, e_ov ? mq[0].size : 3'h0);
    end
    if (reset) begin
      mq.delete(); n_iss = 0; n_done = 0; drop = 0; chk_en = 1;
    end else if (chk_en) begin
      if (fl) begin
        drop = drop + outs + ((e_rv && req_ready) ? 1 : 0)
               - ((resp_valid && (drop > 0 || outs > 0)) ? 1 : 0);
        mq.delete(); n_iss = 0; n_done = 0;
      end else begin
        if (resp_valid) begin
          if (drop > 0) drop--;
          else if (outs > 0) begin
            e = mq[n_done]; e.data = resp_data; mq[n_done] = e; n_done++;
          end
        end
        if (e_rv && req_ready) n_iss++;
        if (e_ov && out_ready) begin
          void'(mq.pop_front()); n_iss--; n_done--;
        end
        if (e_wr) begin
          for (int i = 0; i < 2; i++) begin
            if (wr_en[i]) begin
              e.addr = wr_addr[i*32 +: 32]; e.size = wr_size[i*3 +: 3];
              e.tag = wr_tag[i*8 +: 8]; e.data = '0;
              mq.push_back(e);
            end
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_wr(input logic [1:0] en, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [7:0] t0, input logic [7:0] t1,
                        input logic [2:0] s0, input logic [2:0] s1);
    wr_en = en; wr_addr = {a1, a0}; wr_tag = {t1, t0}; wr_size = {s1, s0};
  endtask

  initial begin
    int guard;
    cyc(2);
    reset = 1'b0;
    chk("rst_empty", empty, 1); chk("rst_wr_ready", wr_ready, 1);
    chk("rst_count", count, 0); chk("rst_req_valid", req_valid, 0);
    chk("rst_out_valid", out_valid, 0);

    // Two loads, responses one cycle after each issue
    req_ready = 1; out_ready = 1;
    set_wr(2'b11, 32'h100, 32'h104, 8'h11, 8'h22, 3'd2, 3'd2);
    cyc(1); wr_en = 2'b00;
    chk("t2_count", count, 2); chk("t2_req_addr0", req_addr, 32'h100);
    cyc(1);
    chk("t2_req_addr1", req_addr, 32'h104);
    resp_valid = 1; resp_data = 32'hAA;
    cyc(1);
    chk("t2_out_valid0", out_valid, 1); chk("t2_out_data0", out_data, 32'hAA);
    chk("t2_out_tag0", out_tag, 8'h11);
    resp_data = 32'hBB;
    cyc(1);
    chk("t2_out_data1", out_data, 32'hBB); chk("t2_out_tag1", out_tag, 8'h22);
    resp_valid = 0;
    cyc(1);
    chk("t2_empty", empty, 1);

    // Upper lane only is compacted to tail
    req_ready = 0; out_ready = 0;
    set_wr(2'b10, 32'hDEAD, 32'h200, 8'h33, 8'h44, 3'd1, 3'd4);
    cyc(1); wr_en = 2'b00;
    chk("t3_count", count, 1); chk("t3_req_addr", req_addr, 32'h200);
    chk("t3_req_size", req_size, 3'd4);

    // Reset mid-operation
    reset = 1; cyc(1); reset = 0;
    chk("t3_rst_count", count, 0); chk("t3_rst_req_valid", req_valid, 0);

    // Fill with the cache stalled
    for (int k = 0; k < 3; k++) begin
      set_wr(2'b11, 32'h300 + 8*k, 32'h304 + 8*k, 8'(2*k), 8'(2*k+1), 3'd2, 3'd1);
      cyc(1);
    end
    chk("t4_count6", count, 6); chk("t4_wr_ready6", wr_ready, 1);
    set_wr(2'b11, 32'h318, 32'h31C, 8'h06, 8'h07, 3'd2, 3'd1);
    cyc(1);
    chk("t4_count8", count, 8); chk("t4_wr_ready8", wr_ready, 0);
    set_wr(2'b11, 32'hBAD0, 32'hBAD4, 8'hEE, 8'hEF, 3'd0, 3'd0);
    cyc(1); wr_en = 2'b00;
    chk("t4_dropped", count, 8); chk("t4_req_stable", req_addr, 32'h300);

    // Outstanding limit
    req_ready = 1;
    cyc(4);
    chk("t5_limit", req_valid, 0);
    cyc(2);
    chk("t5_limit_hold", req_valid, 0);
    resp_valid = 1; resp_data = 32'h55;
    cyc(1); resp_valid = 0;
    chk("t5_resume", req_valid, 1); chk("t5_next_addr", req_addr, 32'h310);
    chk("t5_out_data", out_data, 32'h55);

    // Mixed traffic against the model
    for (int i = 0; i < 40; i++) begin
      wr_en = (i % 4 == 0) ? 2'b11 : (i % 4 == 1) ? 2'b10 : (i % 4 == 2) ? 2'b01 : 2'b00;
      wr_addr = {32'h1004 + 32'(8*i), 32'h1000 + 32'(8*i)};
      wr_tag = {8'(2*i+1), 8'(2*i)};
      wr_size = {3'(i % 5), 3'(i % 3)};
      req_ready = (i % 4 != 3);
      resp_valid = (i % 3 != 2);
      resp_data = 32'hC000 + 32'(i);
      out_ready = (i % 5 != 4);
      cyc(1);
    end
    wr_en = 2'b00; req_ready = 1; resp_valid = 1; out_ready = 1;
    guard = 0;
    while (!empty && guard < 200) begin
      resp_data = 32'hD000 + 32'(guard);
      cyc(1); guard++;
    end
    chk("drain_empty", empty, 1);
    resp_valid = 0;
    cyc(1);

`ifdef LOAD_QUEUE_FLUSH_EN
    set_wr(2'b11, 32'h400, 32'h404, 8'h50, 8'h51, 3'd2, 3'd2);
    cyc(1);
    set_wr(2'b01, 32'h408, 32'h0, 8'h52, 8'h0, 3'd2, 3'd0);
    cyc(1); wr_en = 2'b00;
    cyc(2);
    chk("fl_issued_all", req_valid, 0);
    flush = 1; cyc(1); flush = 0;
    chk("fl_count", count, 0);
    resp_valid = 1; resp_data = 32'hF0;
    for (int i = 0; i < 3; i++) begin
      set_wr(i == 0 ? 2'b01 : 2'b00, 32'h500, 32'h0, 8'h60, 8'h0, 3'd2, 3'd0);
      cyc(1);
      chk("fl_drop_out", out_valid, 0);
      chk("fl_drop_req", req_valid, (i == 2) ? 1 : 0);
    end
    wr_en = 2'b00; resp_valid = 0;
    cyc(1);
    resp_valid = 1; resp_data = 32'h77;
    cyc(1); resp_valid = 0;
    chk("fl_new_valid", out_valid, 1); chk("fl_new_data", out_data, 32'h77);
    chk("fl_new_tag", out_tag, 8'h60);
    cyc(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
